midi_message_tx: RTL and testbench

- Transmit-side counterpart of the MIDI input path.
- Accepts a complete MIDI message (status byte plus up to two data bytes) over a valid/ready handshake.
- Derives the message length from the status byte and serialises the bytes onto MIDI_OUT as 31250 baud 8N1 frames, LSB first.
- Sits between the synth control logic (voice allocator / patch echo) and the MIDI OUT/THRU pin.

---
 rtl/midi_message_tx_if.sv | 31 +++
 rtl/midi_message_tx.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_midi_message_tx.sv | 398 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/midi_message_tx_if.sv
// Message handshake bundle between the synth control logic and the MIDI
// transmitter: valid/ready plus the status byte and two data bytes.
`timescale 1ns/1ps

interface midi_message_tx_if #(
  parameter int BYTE_W = 8
);
  logic              msg_valid;
  logic              msg_ready;
  logic [BYTE_W-1:0] MSG_CMD;
  logic [BYTE_W-1:0] MSG_DAT_0;
  logic [BYTE_W-1:0] MSG_DAT_1;

  // Producer side (voice allocator / patch echo)
  modport master (
    output msg_valid,
    output MSG_CMD,
    output MSG_DAT_0,
    output MSG_DAT_1,
    input  msg_ready
  );

  // Transmitter side
  modport slave (
    input  msg_valid,
    input  MSG_CMD,
    input  MSG_DAT_0,
    input  MSG_DAT_1,
    output msg_ready
  );
endinterface

// File: rtl/midi_message_tx.sv
// MIDI message transmitter: accepts one complete message (status plus up to
// two data bytes), derives its length from the status byte and serialises it
// onto MIDI_OUT as 8N1 frames, LSB first, BIT_CYCLES sys_clk cycles per bit.
//
// Optional feature macro: MIDI_TX_RUNNING_STATUS_EN
//   When defined, a channel status byte equal to the last one sent is omitted
//   (running status). When undefined, the status byte is always sent.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | line high, msg_ready high, waiting for msg_valid
// S_LOAD  | one cycle: validate status, compute length, pick first byte
// S_START | start bit (line low) for BIT_CYCLES cycles
// S_DATA  | BYTE_W data bits, LSB first, BIT_CYCLES cycles each
// S_STOP  | stop bit (line high) for BIT_CYCLES cycles
// S_NEXT  | one idle-high cycle between bytes, advance byte index
// S_DONE  | one cycle with msg_done high, then back to idle
`timescale 1ns/1ps

module midi_message_tx #(
  parameter int BYTE_W    = 8,
  parameter int MIDI_BAUD = 31250,
  parameter int SYSCLK_F  = 48000000
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  midi_message_tx_if.slave msg_if,
  output logic             MIDI_OUT,
  output logic             msg_done,
  output logic             msg_err
);

  // Truncated integer division; the resulting bit-time error is accepted.
  localparam int BIT_CYCLES = SYSCLK_F / MIDI_BAUD;
  localparam int CNT_W      = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int BIT_W      = (BYTE_W > 1) ? $clog2(BYTE_W) : 1;
  localparam logic [CNT_W-1:0] BAUD_TC  = CNT_W'(BIT_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BYTE_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_DATA,
    S_STOP,
    S_NEXT,
    S_DONE
  } state_t;

  state_t            state_q,    state_d;
  logic [CNT_W-1:0]  baud_cnt_q, baud_cnt_d;
  logic [BIT_W-1:0]  bit_cnt_q,  bit_cnt_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [1:0]        last_idx_q, last_idx_d;
  logic [BYTE_W-1:0] cmd_q,      cmd_d;
  logic [BYTE_W-1:0] dat0_q,     dat0_d;
  logic [BYTE_W-1:0] dat1_q,     dat1_d;
  logic [BYTE_W-1:0] shift_q,    shift_d;
  logic              midi_out_q, midi_out_d;
  logic              msg_ready_q, msg_ready_d;
  logic              msg_done_q, msg_done_d;
  logic              msg_err_q,  msg_err_d;
`ifdef MIDI_TX_RUNNING_STATUS_EN
  logic [BYTE_W-1:0] run_stat_q, run_stat_d;
`endif

  logic       baud_tc;
  logic       is_system;
  logic [1:0] msg_len;
  logic [1:0] first_idx;

  // Number of bytes in a message, including the status byte.
  function automatic logic [1:0] len_of(input logic [BYTE_W-1:0] cmd);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = cmd[BYTE_W-1 -: 4];
    lo = cmd[3:0];
    case (hi)
      4'hC, 4'hD: len_of = 2'd2;
      4'hF: begin
        if (lo == 4'h2)                      len_of = 2'd3;
        else if (lo == 4'h1 || lo == 4'h3)   len_of = 2'd2;
        else                                 len_of = 2'd1;
      end
      default:    len_of = 2'd3;
    endcase
  endfunction

  // Byte on the wire for a given index; data bytes always have bit 7 cleared.
  function automatic logic [BYTE_W-1:0] byte_at(
    input logic [1:0]        idx,
    input logic [BYTE_W-1:0] cmd,
    input logic [BYTE_W-1:0] d0,
    input logic [BYTE_W-1:0] d1
  );
    case (idx)
      2'd0:    byte_at = cmd;
      2'd1:    byte_at = {1'b0, d0[BYTE_W-2:0]};
      default: byte_at = {1'b0, d1[BYTE_W-2:0]};
    endcase
  endfunction

  assign baud_tc   = (baud_cnt_q == BAUD_TC);
  assign is_system = (cmd_q[BYTE_W-1 -: 4] == 4'hF);
  assign msg_len   = len_of(cmd_q);

  // First byte index: skip the status byte on a running-status hit.
  always_comb begin
    first_idx = 2'd0;
`ifdef MIDI_TX_RUNNING_STATUS_EN
    if (!is_system && (cmd_q == run_stat_q)) begin
      first_idx = 2'd1;
    end
`endif
  end

  // Next-state and registered-output computation for the whole transmitter.
  always_comb begin
    state_d     = state_q;
    baud_cnt_d  = baud_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    byte_idx_d  = byte_idx_q;
    last_idx_d  = last_idx_q;
    cmd_d       = cmd_q;
    dat0_d      = dat0_q;
    dat1_d      = dat1_q;
    shift_d     = shift_q;
    midi_out_d  = midi_out_q;
    msg_ready_d = msg_ready_q;
    msg_done_d  = 1'b0;
    msg_err_d   = 1'b0;
`ifdef MIDI_TX_RUNNING_STATUS_EN
    run_stat_d  = run_stat_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        midi_out_d  = 1'b1;
        msg_ready_d = 1'b1;
        if (msg_if.msg_valid && msg_ready_q) begin
          cmd_d       = msg_if.MSG_CMD;
          dat0_d      = msg_if.MSG_DAT_0;
          dat1_d      = msg_if.MSG_DAT_1;
          msg_ready_d = 1'b0;
          state_d     = S_LOAD;
        end
      end

      S_LOAD: begin
        if (!cmd_q[BYTE_W-1]) begin
          // Not a status byte: flag it and drop the message. msg_ready
          // rises on the following cycle from S_IDLE.
          msg_err_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          byte_idx_d = first_idx;
          last_idx_d = msg_len - 2'd1;
          shift_d    = byte_at(first_idx, cmd_q, dat0_q, dat1_q);
          baud_cnt_d = '0;
          midi_out_d = 1'b0;
          state_d    = S_START;
`ifdef MIDI_TX_RUNNING_STATUS_EN
          // Channel status loads the register, system common clears it,
          // real-time leaves it alone.
          if (!is_system) begin
            run_stat_d = cmd_q;
          end else if (!cmd_q[3]) begin
            run_stat_d = '0;
          end
`endif
        end
      end

      S_START: begin
        if (baud_tc) begin
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
          midi_out_d = shift_q[0];
          shift_d    = shift_q >> 1;
          state_d    = S_DATA;
        end else begin
          baud_cnt_d = baud_cnt_q + CNT_W'(1);
        end
      end

      S_DATA: begin
        if (baud_tc) begin
          baud_cnt_d = '0;
          if (bit_cnt_q == BIT_LAST) begin
            midi_out_d = 1'b1;
            state_d    = S_STOP;
          end else begin
            bit_cnt_d  = bit_cnt_q + BIT_W'(1);
            midi_out_d = shift_q[0];
            shift_d    = shift_q >> 1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + CNT_W'(1);
        end
      end

      S_STOP: begin
        midi_out_d = 1'b1;
        if (baud_tc) begin
          baud_cnt_d = '0;
          if (byte_idx_q == last_idx_q) begin
            msg_done_d = 1'b1;
            state_d    = S_DONE;
          end else begin
            state_d    = S_NEXT;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + CNT_W'(1);
        end
      end

      S_NEXT: begin
        byte_idx_d = byte_idx_q + 2'd1;
        shift_d    = byte_at(byte_idx_q + 2'd1, cmd_q, dat0_q, dat1_q);
        baud_cnt_d = '0;
        midi_out_d = 1'b0;
        state_d    = S_START;
      end

      S_DONE: begin
        msg_ready_d = 1'b1;
        state_d     = S_IDLE;
      end

      default: begin
        midi_out_d  = 1'b1;
        msg_ready_d = 1'b1;
        state_d     = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset forces the line high immediately.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      baud_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      byte_idx_q  <= '0;
      last_idx_q  <= '0;
      cmd_q       <= '0;
      dat0_q      <= '0;
      dat1_q      <= '0;
      shift_q     <= '0;
      midi_out_q  <= 1'b1;
      msg_ready_q <= 1'b1;
      msg_done_q  <= 1'b0;
      msg_err_q   <= 1'b0;
`ifdef MIDI_TX_RUNNING_STATUS_EN
      run_stat_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      baud_cnt_q  <= baud_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_idx_q  <= byte_idx_d;
      last_idx_q  <= last_idx_d;
      cmd_q       <= cmd_d;
      dat0_q      <= dat0_d;
      dat1_q      <= dat1_d;
      shift_q     <= shift_d;
      midi_out_q  <= midi_out_d;
      msg_ready_q <= msg_ready_d;
      msg_done_q  <= msg_done_d;
      msg_err_q   <= msg_err_d;
`ifdef MIDI_TX_RUNNING_STATUS_EN
      run_stat_q  <= run_stat_d;
`endif
    end
  end

  assign MIDI_OUT         = midi_out_q;
  assign msg_done         = msg_done_q;
  assign msg_err          = msg_err_q;
  assign msg_if.msg_ready = msg_ready_q;

endmodule

// File: tb/tb_midi_message_tx.sv
// Testbench for midi_message_tx. A short bit time keeps runs small; a serial
// monitor decodes MIDI_OUT and checks each frame against a scoreboard queue
// that is filled by a behavioural message model when stimulus is driven.
`timescale 1ns/1ps

module tb_midi_message_tx;

  localparam int SYS_F   = 48000000;
  localparam int BAUD    = 3000000;
  localparam int BC      = SYS_F / BAUD;   // 16 cycles per bit
  localparam int TIMEOUT = 40 * BC + 100;

  logic sys_clk = 1'b0;
  logic rst_n;
  logic midi_out;
  logic msg_done;
  logic msg_err;

  int errors = 0;
  int checks = 0;

  logic [7:0] sb[$];
`ifdef MIDI_TX_RUNNING_STATUS_EN
  logic [7:0] model_rs = 8'h00;
`endif

  midi_message_tx_if #(.BYTE_W(8)) bus();

  midi_message_tx #(
    .BYTE_W   (8),
    .MIDI_BAUD(BAUD),
    .SYSCLK_F (SYS_F)
  ) dut (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .msg_if  (bus.slave),
    .MIDI_OUT(midi_out),
    .msg_done(msg_done),
    .msg_err (msg_err)
  );

  always #5 sys_clk = ~sys_clk;

  // Behavioural model: pushes the bytes expected on the wire, returns count.
  function automatic int model_push(input logic [7:0] c, input logic [7:0] d0,
                                    input logic [7:0] d1);
    int n;
    int first;
    logic [7:0] b [3];
    if (c[7] == 1'b0) return 0;
    case (c[7:4])
      4'hC, 4'hD: n = 2;
      4'hF:       n = (c == 8'hF2) ? 3 : ((c == 8'hF1 || c == 8'hF3) ? 2 : 1);
      default:    n = 3;
    endcase
    b[0] = c;
    b[1] = {1'b0, d0[6:0]};
    b[2] = {1'b0, d1[6:0]};
    first = 0;
`ifdef MIDI_TX_RUNNING_STATUS_EN
    if (c < 8'hF0 && c == model_rs) first = 1;
    if (c < 8'hF0)      model_rs = c;
    else if (c < 8'hF8) model_rs = 8'h00;
`endif
    for (int i = first; i < n; i++) sb.push_back(b[i]);
    return n - first;
  endfunction

  // Serial monitor: decodes 8N1 frames at mid-bit and checks the scoreboard.
  bit         mon_busy = 1'b0;
  int         mon_cnt  = 0;
  logic [7:0] mon_sh   = 8'h00;
  logic [7:0] mon_exp;
  always @(negedge sys_clk) begin
    if (rst_n !== 1'b1) begin
      mon_busy = 1'b0;
    end else if (!mon_busy) begin
      if (midi_out === 1'b0) begin
        mon_busy = 1'b1;
        mon_cnt  = 0;
      end
    end else begin
      mon_cnt++;
    end
    if (mon_busy && mon_cnt >= BC / 2 && ((mon_cnt - BC / 2) % BC) == 0) begin
      int k;
      k = (mon_cnt - BC / 2) / BC;
      if (k == 0) begin
        checks++;
        if (midi_out !== 1'b0) begin
          errors++;
          $display("FAIL start_bit: line=%b want 0 at t=%0t", midi_out, $time);
        end
      end else if (k <= 8) begin
        mon_sh[k-1] = midi_out;
      end else begin
        mon_busy = 1'b0;
        checks++;
        if (midi_out !== 1'b1) begin
          errors++;
          $display("FAIL stop_bit: line=%b want 1 at t=%0t", midi_out, $time);
        end
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL frame_unexpected: got 0x%02h want no frame at t=%0t", mon_sh, $time);
        end else begin
          mon_exp = sb.pop_front();
          if (mon_sh !== mon_exp) begin
            errors++;
            $display("FAIL frame_data: got 0x%02h want 0x%02h at t=%0t", mon_sh, mon_exp, $time);
          end
        end
      end
    end
  end

  // Offer one message, then count cycles after the accept edge until
  // msg_done or msg_err (lat = -1 when the bound expires).
  task automatic run_msg(input logic [7:0] c, input logic [7:0] d0, input logic [7:0] d1,
                         output int lat, output bit held);
    @(negedge sys_clk);
    bus.MSG_CMD   = c;
    bus.MSG_DAT_0 = d0;
    bus.MSG_DAT_1 = d1;
    bus.msg_valid = 1'b1;
    @(posedge sys_clk);
    #1 bus.msg_valid = 1'b0;
    lat  = -1;
    held = 1'b1;
    for (int i = 1; i <= TIMEOUT; i++) begin
      @(posedge sys_clk);
      #1;
      if (msg_done === 1'b1 || msg_err === 1'b1) begin
        lat = i;
        break;
      end
      if (bus.msg_ready !== 1'b0) held = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.msg_valid = 1'b0;
    bus.MSG_CMD   = 8'h00;
    bus.MSG_DAT_0 = 8'h00;
    bus.MSG_DAT_1 = 8'h00;
    repeat (3) @(negedge sys_clk);
    checks++;
    if (midi_out !== 1'b1) begin errors++; $display("FAIL reset_midi_out: got %b want 1", midi_out); end
    checks++;
    if (bus.msg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.msg_ready); end
    checks++;
    if (msg_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", msg_done); end
    checks++;
    if (msg_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", msg_err); end
    rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);
    checks++;
    if (bus.msg_ready !== 1'b1 || midi_out !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_idle: ready=%b line=%b want 1 1", bus.msg_ready, midi_out);
    end
  endtask

  task automatic test_note_on();
    int n, lat;
    bit held;
    n = model_push(8'h90, 8'h3C, 8'h64);
    run_msg(8'h90, 8'h3C, 8'h64, lat, held);
    checks++;
    if (lat != n * (10 * BC + 1)) begin
      errors++; $display("FAIL note_on_latency: got %0d want %0d", lat, n * (10 * BC + 1));
    end
    checks++;
    if (msg_err !== 1'b0) begin errors++; $display("FAIL note_on_err: got %b want 0", msg_err); end
    checks++;
    if (!held) begin errors++; $display("FAIL note_on_ready_low: got ready high want low while busy"); end
    checks++;
    if (bus.msg_ready !== 1'b0) begin errors++; $display("FAIL note_on_ready_at_done: got %b want 0", bus.msg_ready); end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL note_on_frames: got %0d left want 0", sb.size()); end
    @(posedge sys_clk);
    #1;
    checks++;
    if (msg_done !== 1'b0 || bus.msg_ready !== 1'b1) begin
      errors++; $display("FAIL note_on_after_done: done=%b ready=%b want 0 1", msg_done, bus.msg_ready);
    end
  endtask

  // Table-driven run over a list of messages; shared by length and
  // running-status scenarios through separate tables.
  logic [7:0] len_tbl [7][3];
  logic [7:0] rs_tbl  [7][3];

  task automatic test_lengths();
    int n, lat;
    bit held;
    len_tbl = '{'{8'hC5, 8'h07, 8'h99}, '{8'hB0, 8'hFF, 8'h80}, '{8'hF8, 8'h00, 8'h00},
                '{8'hF2, 8'h12, 8'hB4}, '{8'hF1, 8'h55, 8'h00}, '{8'hE3, 8'h7F, 8'hC0},
                '{8'hFE, 8'h11, 8'h22}};
    for (int t = 0; t < 7; t++) begin
      n = model_push(len_tbl[t][0], len_tbl[t][1], len_tbl[t][2]);
      run_msg(len_tbl[t][0], len_tbl[t][1], len_tbl[t][2], lat, held);
      checks++;
      if (lat != n * (10 * BC + 1)) begin
        errors++; $display("FAIL len_latency[%0d]: got %0d want %0d", t, lat, n * (10 * BC + 1));
      end
      checks++;
      if (msg_done !== 1'b1 || msg_err !== 1'b0) begin
        errors++; $display("FAIL len_done[%0d]: done=%b err=%b want 1 0", t, msg_done, msg_err);
      end
      checks++;
      if (!held) begin errors++; $display("FAIL len_ready_low[%0d]: got high want low", t); end
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL len_frames[%0d]: got %0d left want 0", t, sb.size()); end
      @(posedge sys_clk);
      #1;
      checks++;
      if (msg_done !== 1'b0 || bus.msg_ready !== 1'b1) begin
        errors++; $display("FAIL len_after_done[%0d]: done=%b ready=%b want 0 1", t, msg_done, bus.msg_ready);
      end
    end
  endtask

  task automatic test_reject();
    int n, lat;
    bit held;
    n = model_push(8'h45, 8'h01, 8'h02);
    run_msg(8'h45, 8'h01, 8'h02, lat, held);
    checks++;
    if (lat != 1 || msg_err !== 1'b1 || n != 0) begin
      errors++; $display("FAIL reject_err: lat=%0d err=%b want 1 1", lat, msg_err);
    end
    checks++;
    if (msg_done !== 1'b0 || bus.msg_ready !== 1'b0) begin
      errors++; $display("FAIL reject_state: done=%b ready=%b want 0 0", msg_done, bus.msg_ready);
    end
    @(posedge sys_clk);
    #1;
    checks++;
    if (bus.msg_ready !== 1'b1 || msg_err !== 1'b0) begin
      errors++; $display("FAIL reject_recover: ready=%b err=%b want 1 0", bus.msg_ready, msg_err);
    end
    repeat (4 * BC) @(posedge sys_clk);
    #1;
    checks++;
    if (midi_out !== 1'b1) begin errors++; $display("FAIL reject_line: got %b want 1", midi_out); end
  endtask

  task automatic test_running_status();
    int n, lat;
    bit held;
    rs_tbl = '{'{8'h90, 8'h3C, 8'h64}, '{8'h90, 8'h40, 8'h00}, '{8'hF8, 8'h00, 8'h00},
               '{8'h90, 8'h41, 8'h00}, '{8'hF3, 8'h01, 8'h00}, '{8'h90, 8'h42, 8'h00},
               '{8'h80, 8'h3C, 8'h00}};
    for (int t = 0; t < 7; t++) begin
      n = model_push(rs_tbl[t][0], rs_tbl[t][1], rs_tbl[t][2]);
      run_msg(rs_tbl[t][0], rs_tbl[t][1], rs_tbl[t][2], lat, held);
      checks++;
      if (lat != n * (10 * BC + 1)) begin
        errors++; $display("FAIL rs_latency[%0d]: got %0d want %0d", t, lat, n * (10 * BC + 1));
      end
      checks++;
      if (msg_done !== 1'b1 || msg_err !== 1'b0 || !held) begin
        errors++; $display("FAIL rs_done[%0d]: done=%b err=%b held=%0d want 1 0 1", t, msg_done, msg_err, held);
      end
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL rs_frames[%0d]: got %0d left want 0", t, sb.size()); end
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic test_busy_ignore();
    int n, lat;
    bit err_seen;
    n = model_push(8'hA1, 8'h22, 8'h33);
    @(negedge sys_clk);
    bus.MSG_CMD   = 8'hA1;
    bus.MSG_DAT_0 = 8'h22;
    bus.MSG_DAT_1 = 8'h33;
    bus.msg_valid = 1'b1;
    @(posedge sys_clk);
    #1;
    bus.MSG_CMD   = 8'h45;
    bus.MSG_DAT_0 = 8'h11;
    bus.MSG_DAT_1 = 8'h12;
    lat      = -1;
    err_seen = 1'b0;
    for (int i = 1; i <= TIMEOUT; i++) begin
      @(posedge sys_clk);
      #1;
      if (msg_err === 1'b1) err_seen = 1'b1;
      if (msg_done === 1'b1) begin
        lat = i;
        break;
      end
    end
    bus.msg_valid = 1'b0;
    checks++;
    if (lat != n * (10 * BC + 1)) begin
      errors++; $display("FAIL busy_latency: got %0d want %0d", lat, n * (10 * BC + 1));
    end
    checks++;
    if (err_seen) begin errors++; $display("FAIL busy_err: got err pulse want none"); end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL busy_frames: got %0d left want 0", sb.size()); end
    repeat (3) @(posedge sys_clk);
    #1;
    checks++;
    if (bus.msg_ready !== 1'b1 || msg_err !== 1'b0) begin
      errors++; $display("FAIL busy_after: ready=%b err=%b want 1 0", bus.msg_ready, msg_err);
    end
  endtask

  task automatic test_reset_midframe();
    int n, lat;
    bit held;
    bit done_seen;
    n = model_push(8'h90, 8'h37, 8'h64);
    @(negedge sys_clk);
    bus.MSG_CMD   = 8'h90;
    bus.MSG_DAT_0 = 8'h37;
    bus.MSG_DAT_1 = 8'h64;
    bus.msg_valid = 1'b1;
    @(posedge sys_clk);
    #1 bus.msg_valid = 1'b0;
    // Second byte's start bit begins 10*BC+2 edges after accept; bit 3 four bits later.
    repeat (14 * BC + 2 + BC / 2) @(posedge sys_clk);
    @(negedge sys_clk);
    checks++;
    if (midi_out !== 1'b0) begin errors++; $display("FAIL midframe_bit3: got %b want 0", midi_out); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (midi_out !== 1'b1) begin errors++; $display("FAIL midframe_async_high: got %b want 1", midi_out); end
    sb.delete();
`ifdef MIDI_TX_RUNNING_STATUS_EN
    model_rs = 8'h00;
`endif
    done_seen = 1'b0;
    repeat (3) begin
      @(negedge sys_clk);
      if (msg_done === 1'b1) done_seen = 1'b1;
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge sys_clk);
      if (msg_done === 1'b1) done_seen = 1'b1;
    end
    checks++;
    if (done_seen) begin errors++; $display("FAIL midframe_done: got done pulse want none"); end
    checks++;
    if (bus.msg_ready !== 1'b1 || midi_out !== 1'b1) begin
      errors++; $display("FAIL midframe_recover: ready=%b line=%b want 1 1", bus.msg_ready, midi_out);
    end
    // 0x90 right after reset: running status must have been cleared.
    n = model_push(8'h90, 8'h3C, 8'h00);
    run_msg(8'h90, 8'h3C, 8'h00, lat, held);
    checks++;
    if (lat != n * (10 * BC + 1) || n != 3) begin
      errors++; $display("FAIL midframe_fresh90: lat=%0d want %0d", lat, 3 * (10 * BC + 1));
    end
    @(posedge sys_clk);
    #1;
    n = model_push(8'h80, 8'h3C, 8'h00);
    run_msg(8'h80, 8'h3C, 8'h00, lat, held);
    checks++;
    if (lat != n * (10 * BC + 1) || !held) begin
      errors++; $display("FAIL midframe_fresh80: lat=%0d held=%0d want %0d 1", lat, held, n * (10 * BC + 1));
    end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL midframe_frames: got %0d left want 0", sb.size()); end
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_note_on();
    test_lengths();
    test_reject();
    test_running_status();
    test_busy_ignore();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #(800000);
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
